serial_fa_adder: RTL

//  Bit-serial multi-bit adder built around one full-adder cell (s=a^b^cin,
//  c=maj(a,b,cin)) and a registered carry. Consumes the single-bit sum and

---
 rtl/serial_fa_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_fa_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB first.
// Optional macro SERIAL_FA_OVF_EN adds a registered two's-complement overflow output.
module serial_fa_adder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
`ifdef SERIAL_FA_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] sum_nxt;

    // Full-adder cell on the current LSBs and the fed-back carry
    assign bit_s   = a_sr[0] ^ b_sr[0] ^ cy;
    assign bit_c   = (a_sr[0] & b_sr[0]) | (b_sr[0] & cy) | (a_sr[0] & cy);
    // Bit shifted out of sum_nxt[0] is always stale except on the last edge
    assign sum_nxt = {bit_s, sum_sr};
    assign last    = (state == RUN) && (cnt == CNT_W'(WIDTH-1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                load      = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cy     <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            c      <= 1'b0;
`ifdef SERIAL_FA_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            cy   <= cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_nxt[WIDTH-1:1];
            cy     <= bit_c;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                s <= sum_nxt;
                c <= bit_c;
`ifdef SERIAL_FA_OVF_EN
                // cy here is the carry into the MSB
                ovf <= cy ^ bit_c;
`endif
            end
        end
    end

endmodule
